// File: rtl/smi_frame_pkg.sv
// Shared SMI frame definitions: frame type bytes, end-of-frame marker and the
// request splitter state encoding.
package smi_frame_pkg;

  localparam logic [7:0] SMI_READ_REQ_ID   = 8'h02;
  localparam logic [7:0] SMI_WRITE_REQ_ID  = 8'h01;
  localparam logic [7:0] SMI_READ_RESP_ID  = 8'hFD;
  localparam logic [7:0] SMI_WRITE_RESP_ID = 8'hFE;
  localparam logic [7:0] SMI_EOFC_MID      = 8'd0;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    FwdRead  = 2'd1,
    FwdWrite = 2'd2,
    Discard  = 2'd3
  } splitState_t;

  function automatic logic isLastFlit(input logic [7:0] eofc);
    return eofc != SMI_EOFC_MID;
  endfunction

endpackage

// File: rtl/smi_skid_buffer.sv
// Two-entry Ready/Stop buffer: flits enter the skid entry and move to the head
// entry that drives the output, so the upstream sees Stop only when both are full.
module smi_skid_buffer #(
  parameter int DataWidth = 128
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 inReady,
  input  logic [7:0]           inEofc,
  input  logic [DataWidth-1:0] inData,
  output logic                 inStop,
  output logic                 outReady,
  output logic [7:0]           outEofc,
  output logic [DataWidth-1:0] outData,
  input  logic                 outStop
);

  logic                 skidValid;
  logic                 headValid;
  logic [7:0]           skidEofc;
  logic [DataWidth-1:0] skidData;
  logic [7:0]           headEofc;
  logic [DataWidth-1:0] headData;
  logic                 headLoad;
  logic                 skidLoad;
  logic                 inPush;

  // Head can take a new entry when it is empty or being drained this cycle.
  assign headLoad = !headValid || !outStop;
  assign inStop   = skidValid && headValid && outStop;
  assign inPush   = inReady && !inStop;
  assign skidLoad = !skidValid || headLoad;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      skidValid <= 1'b0;
      headValid <= 1'b0;
    end else begin
      if (skidLoad) skidValid <= inPush;
      if (headLoad) headValid <= skidValid;
    end
  end

  always_ff @(posedge clk) begin
    if (skidLoad && inPush) begin
      skidEofc <= inEofc;
      skidData <= inData;
    end
    if (headLoad && skidValid) begin
      headEofc <= skidEofc;
      headData <= skidData;
    end
  end

  assign outReady = headValid;
  assign outEofc  = headEofc;
  assign outData  = headData;

endmodule

// File: rtl/smi_request_type_split.sv
// Splits one SMI request stream into read and write request streams by the
// type byte of each frame's head flit; unknown frames are dropped and counted.
//
// state    | meaning
// Idle     | waiting for a frame head in the input register; decode its type
// FwdRead  | forwarding body flits of a read frame to the read output
// FwdWrite | forwarding body flits of a write frame to the write output
// Discard  | consuming body flits of an unrecognised frame
module smi_request_type_split
  import smi_frame_pkg::*;
#(
  parameter int DataIndexSize = 4,
  parameter int DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 smiRdReady,
  output logic [7:0]           smiRdEofc,
  output logic [DataWidth-1:0] smiRdData,
  input  logic                 smiRdStop,
  output logic                 smiWrReady,
  output logic [7:0]           smiWrEofc,
  output logic [DataWidth-1:0] smiWrData,
  input  logic                 smiWrStop,
  output logic [15:0]          dropCount
);

  splitState_t          state;
  splitState_t          nextState;
  logic                 inValid;
  logic [7:0]           inEofc;
  logic [DataWidth-1:0] inData;
  logic                 inLoad;
  logic                 consume;
  logic                 rdPush;
  logic                 wrPush;
  logic                 rdBufStop;
  logic                 wrBufStop;
  logic                 dropDone;
  logic                 inLast;

  assign inLast     = isLastFlit(inEofc);
  assign smiReqStop = inValid && !consume;
  assign inLoad     = !smiReqStop;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) inValid <= 1'b0;
    else if (inLoad) inValid <= smiReqReady;
  end

  always_ff @(posedge clk) begin
    if (inLoad && smiReqReady) begin
      inEofc <= smiReqEofc;
      inData <= smiReqData;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= Idle;
    else state <= nextState;
  end

  always_comb begin
    nextState = state;
    consume   = 1'b0;
    rdPush    = 1'b0;
    wrPush    = 1'b0;
    dropDone  = 1'b0;
    case (state)
      Idle: begin
        if (inValid) begin
          case (inData[7:0])
            SMI_READ_REQ_ID: begin
              rdPush  = 1'b1;
              consume = !rdBufStop;
              if (consume && !inLast) nextState = FwdRead;
            end
            SMI_WRITE_REQ_ID: begin
              wrPush  = 1'b1;
              consume = !wrBufStop;
              if (consume && !inLast) nextState = FwdWrite;
            end
            // Responses have no business on the request stream.
            SMI_READ_RESP_ID, SMI_WRITE_RESP_ID: begin
              consume = 1'b1;
              if (inLast) dropDone = 1'b1;
              else nextState = Discard;
            end
            default: begin
              consume = 1'b1;
              if (inLast) dropDone = 1'b1;
              else nextState = Discard;
            end
          endcase
        end
      end
      FwdRead: begin
        rdPush  = inValid;
        consume = inValid && !rdBufStop;
        if (consume && inLast) nextState = Idle;
      end
      FwdWrite: begin
        wrPush  = inValid;
        consume = inValid && !wrBufStop;
        if (consume && inLast) nextState = Idle;
      end
      Discard: begin
        consume = inValid;
        if (consume && inLast) begin
          dropDone  = 1'b1;
          nextState = Idle;
        end
      end
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) dropCount <= 16'd0;
    else if (dropDone && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
  end

  smi_skid_buffer #(.DataWidth(DataWidth)) rdBuf (
    .clk      (clk),
    .arstn    (arstn),
    .inReady  (rdPush),
    .inEofc   (inEofc),
    .inData   (inData),
    .inStop   (rdBufStop),
    .outReady (smiRdReady),
    .outEofc  (smiRdEofc),
    .outData  (smiRdData),
    .outStop  (smiRdStop)
  );

  smi_skid_buffer #(.DataWidth(DataWidth)) wrBuf (
    .clk      (clk),
    .arstn    (arstn),
    .inReady  (wrPush),
    .inEofc   (inEofc),
    .inData   (inData),
    .inStop   (wrBufStop),
    .outReady (smiWrReady),
    .outEofc  (smiWrEofc),
    .outData  (smiWrData),
    .outStop  (smiWrStop)
  );

endmodule

// File: tb/tb_smi_request_type_split.sv
// Directed bench for smi_request_type_split: table of frames with hand-computed
// routing and drop counts, plus sequences for latency, throughput, stall and reset.
module tb_smi_request_type_split;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          smiReqReady;
  logic [7:0]    smiReqEofc;
  logic [DW-1:0] smiReqData;
  logic          smiReqStop;
  logic          smiRdReady;
  logic [7:0]    smiRdEofc;
  logic [DW-1:0] smiRdData;
  logic          smiRdStop;
  logic          smiWrReady;
  logic [7:0]    smiWrEofc;
  logic [DW-1:0] smiWrData;
  logic          smiWrStop;
  logic [15:0]   dropCount;

  always #5 clk = ~clk;

  smi_request_type_split #(.DataIndexSize(4)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .smiReqReady (smiReqReady),
    .smiReqEofc  (smiReqEofc),
    .smiReqData  (smiReqData),
    .smiReqStop  (smiReqStop),
    .smiRdReady  (smiRdReady),
    .smiRdEofc   (smiRdEofc),
    .smiRdData   (smiRdData),
    .smiRdStop   (smiRdStop),
    .smiWrReady  (smiWrReady),
    .smiWrEofc   (smiWrEofc),
    .smiWrData   (smiWrData),
    .smiWrStop   (smiWrStop),
    .dropCount   (dropCount)
  );

  typedef struct {
    bit          isWr;
    logic [7:0]  eofc;
    logic [DW-1:0] data;
    int          cyc;
  } out_t;

  typedef struct {
    logic [7:0] typ;
    int         len;
    int         expRd;
    int         expWr;
    int         expDrop;
  } vec_t;

  out_t outQ[$];
  int   cyc = 0;
  int   stopCnt = 0;
  int   total = 0;
  int   bad = 0;

  // Records every output transfer, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    cyc++;
    if (arstn) begin
      if (smiRdReady && !smiRdStop) outQ.push_back('{1'b0, smiRdEofc, smiRdData, cyc});
      if (smiWrReady && !smiWrStop) outQ.push_back('{1'b1, smiWrEofc, smiWrData, cyc});
      if (smiReqStop) stopCnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mkData(input int f, input int k, input logic [7:0] t);
    logic [7:0] lo;
    lo = (k == 0) ? t : ((t == 8'h02) ? 8'h01 : 8'h02);
    return {32'(f), 32'(k), 56'h5A5A_0000_1234_00, lo};
  endfunction

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendFlit(input logic [DW-1:0] d, input logic [7:0] e, output int waits);
    bit done;
    smiReqReady = 1'b1;
    smiReqData  = d;
    smiReqEofc  = e;
    done  = 0;
    waits = 0;
    while (!done) begin
      @(negedge clk);
      done = !smiReqStop;
      @(posedge clk);
      #1;
      waits++;
      if (!done && waits > 200) begin
        total++;
        bad++;
        $display("FAIL sendFlit timeout: flit not accepted after %0d cycles", waits);
        done = 1;
      end
    end
    smiReqReady = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];
  int   w;
  int   base;
  int   s0;
  int   nExp;

  initial begin
    vecs[0] = '{8'h02, 1, 1, 0, 0};
    vecs[1] = '{8'h01, 3, 0, 3, 0};
    vecs[2] = '{8'h7A, 4, 0, 0, 1};
    vecs[3] = '{8'hFF, 1, 0, 0, 2};
    vecs[4] = '{8'h02, 4, 4, 0, 2};
    vecs[5] = '{8'hFD, 2, 0, 0, 3};
    vecs[6] = '{8'h01, 1, 0, 1, 3};
    vecs[7] = '{8'h00, 1, 0, 0, 4};
    vecs[8] = '{8'hFE, 3, 0, 0, 5};
    vecs[9] = '{8'h02, 2, 2, 0, 5};

    smiReqReady = 1'b0;
    smiReqEofc  = 8'd0;
    smiReqData  = '0;
    smiRdStop   = 1'b0;
    smiWrStop   = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset rdReady", 136'(smiRdReady), 136'(0));
    check("reset wrReady", 136'(smiWrReady), 136'(0));
    check("reset reqStop", 136'(smiReqStop), 136'(0));
    check("reset dropCount", 136'(dropCount), 136'(0));
    arstn = 1'b1;

    // Single-flit read: accepted on first edge after release, out after two more edges
    sendFlit(mkData(1, 0, 8'h02), 8'd16, w);
    check("first accept waits", 136'(w), 136'(1));
    check("lat rdReady edge N", 136'(smiRdReady), 136'(0));
    waitCycles(1);
    check("lat rdReady edge N+1", 136'(smiRdReady), 136'(0));
    waitCycles(1);
    check("lat rdReady edge N+2", 136'(smiRdReady), 136'(1));
    check("lat rdData", 136'(smiRdData), 136'(mkData(1, 0, 8'h02)));
    check("lat rdEofc", 136'(smiRdEofc), 136'(16));
    check("lat wrReady", 136'(smiWrReady), 136'(0));
    waitCycles(2);
    check("lat dropCount", 136'(dropCount), 136'(0));

    // Table of frames
    for (int v = 0; v < 10; v++) begin
      base = outQ.size();
      s0   = stopCnt;
      for (int k = 0; k < vecs[v].len; k++)
        sendFlit(mkData(v, k, vecs[v].typ), (k == vecs[v].len - 1) ? 8'd16 : 8'd0, w);
      waitCycles(6);
      nExp = vecs[v].expRd + vecs[v].expWr;
      check($sformatf("vec%0d count", v), 136'(outQ.size() - base), 136'(nExp));
      check($sformatf("vec%0d reqStop cycles", v), 136'(stopCnt - s0), 136'(0));
      check($sformatf("vec%0d dropCount", v), 136'(dropCount), 136'(vecs[v].expDrop));
      for (int k = 0; k < nExp && base + k < outQ.size(); k++) begin
        check($sformatf("vec%0d flit%0d isWr", v, k), 136'(outQ[base+k].isWr), 136'(vecs[v].expWr > 0));
        check($sformatf("vec%0d flit%0d data", v, k), 136'(outQ[base+k].data), 136'(mkData(v, k, vecs[v].typ)));
        check($sformatf("vec%0d flit%0d eofc", v, k), 136'(outQ[base+k].eofc),
              136'((k == nExp - 1) ? 16 : 0));
      end
    end

    // Back-to-back 3-flit write then 2-flit read: five transfers, no bubble
    base = outQ.size();
    for (int k = 0; k < 3; k++) sendFlit(mkData(20, k, 8'h01), (k == 2) ? 8'd16 : 8'd0, w);
    for (int k = 0; k < 2; k++) sendFlit(mkData(21, k, 8'h02), (k == 1) ? 8'd16 : 8'd0, w);
    waitCycles(6);
    check("b2b count", 136'(outQ.size() - base), 136'(5));
    if (outQ.size() - base == 5) begin
      check("b2b span", 136'(outQ[base+4].cyc - outQ[base].cyc), 136'(4));
      for (int k = 0; k < 5; k++) begin
        check($sformatf("b2b%0d isWr", k), 136'(outQ[base+k].isWr), 136'(k < 3));
        check($sformatf("b2b%0d eofc", k), 136'(outQ[base+k].eofc), 136'((k == 2 || k == 4) ? 16 : 0));
        check($sformatf("b2b%0d data", k), 136'(outQ[base+k].data),
              136'((k < 3) ? mkData(20, k, 8'h01) : mkData(21, k - 3, 8'h02)));
      end
    end

    // Read output stalled for 10 cycles during a 6-flit read frame
    base = outQ.size();
    s0   = stopCnt;
    smiRdStop = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) sendFlit(mkData(30, k, 8'h02), (k == 5) ? 8'd16 : 8'd0, w);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        smiRdStop = 1'b0;
      end
    join
    waitCycles(6);
    check("bp reqStop seen", 136'(stopCnt - s0 > 0), 136'(1));
    check("bp count", 136'(outQ.size() - base), 136'(6));
    for (int k = 0; k < 6 && base + k < outQ.size(); k++) begin
      check($sformatf("bp%0d data", k), 136'(outQ[base+k].data), 136'(mkData(30, k, 8'h02)));
      check($sformatf("bp%0d eofc", k), 136'(outQ[base+k].eofc), 136'((k == 5) ? 16 : 0));
    end

    // Reset in the middle of a read frame
    sendFlit(mkData(40, 0, 8'h02), 8'd0, w);
    sendFlit(mkData(40, 1, 8'h02), 8'd0, w);
    waitCycles(1);
    check("rst pre rdReady", 136'(smiRdReady), 136'(1));
    #2;
    arstn = 1'b0;
    #1;
    check("rst rdReady", 136'(smiRdReady), 136'(0));
    check("rst wrReady", 136'(smiWrReady), 136'(0));
    check("rst reqStop", 136'(smiReqStop), 136'(0));
    check("rst dropCount", 136'(dropCount), 136'(0));
    @(posedge clk);
    #1;
    arstn = 1'b1;
    base = outQ.size();
    sendFlit(mkData(41, 0, 8'h01), 8'd4, w);
    check("post-rst accept waits", 136'(w), 136'(1));
    waitCycles(6);
    check("post-rst count", 136'(outQ.size() - base), 136'(1));
    if (outQ.size() - base == 1) begin
      check("post-rst isWr", 136'(outQ[base].isWr), 136'(1));
      check("post-rst data", 136'(outQ[base].data), 136'(mkData(41, 0, 8'h01)));
      check("post-rst eofc", 136'(outQ[base].eofc), 136'(4));
    end

    // Drop counter saturation
    for (int i = 0; i < 65534; i++) sendFlit(mkData(50, 0, 8'h33), 8'd1, w);
    waitCycles(3);
    check("sat dropCount FFFE", 136'(dropCount), 136'(16'hFFFE));
    sendFlit(mkData(51, 0, 8'h33), 8'd1, w);
    waitCycles(3);
    check("sat dropCount FFFF", 136'(dropCount), 136'(16'hFFFF));
    sendFlit(mkData(52, 0, 8'h33), 8'd1, w);
    sendFlit(mkData(53, 0, 8'h33), 8'd1, w);
    waitCycles(3);
    check("sat dropCount hold", 136'(dropCount), 136'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
